// File: rtl/ext_bus_reg_slave_pkg.sv
// Shared definitions for the external-bus register slave: register indices,
// FSM state type and byte-lane merge helpers.
package ext_bus_pkg;

   localparam int IDX_CTRL     = 0;
   localparam int IDX_PEND     = 1;
   localparam int IDX_MASK     = 2;
   localparam int IDX_STATUS   = 3;
   localparam int IDX_SCRATCH0 = 4;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   // Operates on the widest legal bus (32 bits, 4 lanes); callers pad/truncate.
   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] m;
      for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
      return (old_v & ~m) | (new_v & m);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ext_bus_reg_slave_irq_bank.sv
// Interrupt bank: rising-edge detect on irq_src, sticky write-1-to-clear PEND,
// MASK register and a registered level irq.
module ext_bus_irq_bank
   import ext_bus_pkg::*;
#(
   parameter int NUM_IRQ = 4
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic [NUM_IRQ-1:0] clr,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_d,
   output logic [NUM_IRQ-1:0] pend,
   output logic [NUM_IRQ-1:0] mask,
   output logic               irq
);

   logic [NUM_IRQ-1:0] src_d;
   logic [NUM_IRQ-1:0] edge_det;

   assign edge_det = irq_src & ~src_d;

   // A new edge wins over a clear of the same bit in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_d <= '0;
         pend  <= '0;
         mask  <= '0;
         irq   <= 1'b0;
      end else begin
         src_d <= irq_src;
         pend  <= (pend & ~clr) | edge_det;
         if (mask_we) mask <= mask_d;
         irq   <= |(pend & mask);
      end
   end

endmodule

// File: rtl/ext_bus_reg_slave.sv
// Register-file slave on the HPS external bus bridge conduit.
// Optional EXT_BUS_STATS_EN adds a read/write counter register at index NUM_REGS.
module ext_bus_reg_slave
   import ext_bus_pkg::*;
#(
   parameter int ADDR_W      = 17,
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_STATES = 1,
   parameter int CTRL_W      = 8,
   parameter logic [DATA_W-1:0] CTRL_RST = '0,
   parameter int NUM_IRQ     = 4
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                bus_enable,
   input  logic                rw,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byte_enable,
   input  logic [DATA_W-1:0]   write_data,
   output logic [DATA_W-1:0]   read_data,
   output logic                acknowledge,
   output logic                irq,
   output logic [CTRL_W-1:0]   ctrl_out,
   input  logic [NUM_IRQ-1:0]  irq_src,
   input  logic [DATA_W-1:0]   status_in
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = ADDR_W - 2;
   localparam int NSCR  = NUM_REGS - IDX_SCRATCH0;

   state_t                       state;
   logic [3:0]                   cnt;
   logic [IDX_W-1:0]             idx_q;
   logic                         rw_q;
   logic [BE_W-1:0]              be_q;
   logic [DATA_W-1:0]            wdata_q;

   logic [DATA_W-1:0]            ctrl_q;
   logic [NSCR-1:0][DATA_W-1:0]  scratch_q;
   logic [NUM_IRQ-1:0]           pend, mask, clr, mask_d;
   logic                         mask_we;

   logic [IDX_W-1:0]             rd_idx;
   logic [DATA_W-1:0]            rd_val;
   logic [DATA_W-1:0]            be_bits;
   logic                         wr_fire;
   logic                         unused_addr_lsb;

   assign unused_addr_lsb = ^address[1:0];
   assign ctrl_out        = ctrl_q[CTRL_W-1:0];
   assign wr_fire         = (state == ACK) && !rw_q;
   assign be_bits         = DATA_W'(be_merge(32'h0, 32'hFFFF_FFFF, 4'(be_q)));

   // With zero wait states ACK is entered straight from IDLE, before the latch.
   assign rd_idx = (state == IDLE) ? address[ADDR_W-1:2] : idx_q;

`ifdef EXT_BUS_STATS_EN
   localparam int NUM_IDX = NUM_REGS + 1;
   logic [15:0] rd_cnt, wr_cnt;
   logic        in_range;

   assign in_range = idx_q < IDX_W'(NUM_IDX);

   // The access being acknowledged is included in the count it may return.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else if (state == ACK && in_range) begin
         if (!rw_q && idx_q == IDX_W'(NUM_REGS)) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
         end else if (rw_q) begin
            rd_cnt <= sat_inc(rd_cnt);
         end else begin
            wr_cnt <= sat_inc(wr_cnt);
         end
      end
   end
`endif

   always_comb begin
      rd_val = '0;
      if (rd_idx == IDX_W'(IDX_CTRL))   rd_val = ctrl_q;
      if (rd_idx == IDX_W'(IDX_PEND))   rd_val = DATA_W'(pend);
      if (rd_idx == IDX_W'(IDX_MASK))   rd_val = DATA_W'(mask);
      if (rd_idx == IDX_W'(IDX_STATUS)) rd_val = status_in;
      for (int i = 0; i < NSCR; i++)
         if (rd_idx == IDX_W'(IDX_SCRATCH0 + i)) rd_val = scratch_q[i];
`ifdef EXT_BUS_STATS_EN
      if (rd_idx == IDX_W'(NUM_REGS)) rd_val = DATA_W'({wr_cnt, sat_inc(rd_cnt)});
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         idx_q       <= '0;
         rw_q        <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         acknowledge <= 1'b0;
         read_data   <= '0;
      end else begin
         acknowledge <= 1'b0;
         read_data   <= '0;
         case (state)
            IDLE: begin
               if (bus_enable) begin
                  idx_q   <= address[ADDR_W-1:2];
                  rw_q    <= rw;
                  be_q    <= byte_enable;
                  wdata_q <= write_data;
                  cnt     <= 4'(WAIT_STATES);
                  if (WAIT_STATES == 0) begin
                     state       <= ACK;
                     acknowledge <= 1'b1;
                     if (rw) read_data <= rd_val;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state       <= ACK;
                  acknowledge <= 1'b1;
                  if (rw_q) read_data <= rd_val;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Writes land on the edge that closes ACK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q    <= CTRL_RST;
         scratch_q <= '0;
      end else if (wr_fire) begin
         if (idx_q == IDX_W'(IDX_CTRL))
            ctrl_q <= DATA_W'(be_merge(32'(ctrl_q), 32'(wdata_q), 4'(be_q)));
         for (int i = 0; i < NSCR; i++)
            if (idx_q == IDX_W'(IDX_SCRATCH0 + i))
               scratch_q[i] <= DATA_W'(be_merge(32'(scratch_q[i]), 32'(wdata_q), 4'(be_q)));
      end
   end

   assign clr     = (wr_fire && idx_q == IDX_W'(IDX_PEND)) ? NUM_IRQ'(wdata_q & be_bits) : '0;
   assign mask_we = wr_fire && idx_q == IDX_W'(IDX_MASK);
   assign mask_d  = NUM_IRQ'(be_merge(32'(mask), 32'(wdata_q), 4'(be_q)));

   ext_bus_irq_bank #(.NUM_IRQ(NUM_IRQ)) u_irq_bank (
      .clk     (clk),
      .reset   (reset),
      .irq_src (irq_src),
      .clr     (clr),
      .mask_we (mask_we),
      .mask_d  (mask_d),
      .pend    (pend),
      .mask    (mask),
      .irq     (irq)
   );

endmodule

// File: tb/tb_ext_bus_reg_slave.sv
// Randomized bench for ext_bus_reg_slave against a register-map model; u=0 has
// one wait state, u=1 has none. Honours EXT_BUS_STATS_EN when defined.
module tb_ext_bus_reg_slave;

`ifdef EXT_BUS_STATS_EN
   localparam int NIDX = 9;
`else
   localparam int NIDX = 8;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_en [2];
   logic        rw_s   [2];
   logic [16:0] addr_s [2];
   logic [3:0]  be_s   [2];
   logic [31:0] wd_s   [2];
   logic [31:0] st_s   [2];
   logic [31:0] rdata_s[2];
   logic        ack_s  [2];
   logic        irq_s  [2];
   logic [7:0]  ctrl_s [2];
   logic [3:0]  src0, src1;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] m_ctrl, m_pend, m_mask;
   logic [31:0] m_scr [4];
   int          m_rd, m_wr;

   always #5 clk = ~clk;

   ext_bus_reg_slave #(.WAIT_STATES(1)) u_ws1 (
      .clk(clk), .reset(rst), .bus_enable(bus_en[0]), .rw(rw_s[0]), .address(addr_s[0]),
      .byte_enable(be_s[0]), .write_data(wd_s[0]), .read_data(rdata_s[0]),
      .acknowledge(ack_s[0]), .irq(irq_s[0]), .ctrl_out(ctrl_s[0]),
      .irq_src(src0), .status_in(st_s[0]));

   ext_bus_reg_slave #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset(rst), .bus_enable(bus_en[1]), .rw(rw_s[1]), .address(addr_s[1]),
      .byte_enable(be_s[1]), .write_data(wd_s[1]), .read_data(rdata_s[1]),
      .acknowledge(ack_s[1]), .irq(irq_s[1]), .ctrl_out(ctrl_s[1]),
      .irq_src(src1), .status_in(st_s[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic m_reset();
      m_ctrl = 0; m_pend = 0; m_mask = 0; m_rd = 0; m_wr = 0;
      for (int i = 0; i < 4; i++) m_scr[i] = 0;
   endtask

   function automatic logic [31:0] m_read(input int idx, input logic [31:0] st);
      if (idx == 0) return m_ctrl;
      if (idx == 1) return m_pend;
      if (idx == 2) return m_mask;
      if (idx == 3) return st;
      if (idx >= 4 && idx < 8) return m_scr[idx-4];
`ifdef EXT_BUS_STATS_EN
      if (idx == 8) return {16'(m_wr), 16'((m_rd < 65535) ? m_rd + 1 : 65535)};
`endif
      return 32'h0;
   endfunction

   task automatic m_apply(input bit r, input int idx, input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] bm;
      bm = bmask(be);
      if (!r) begin
         if (idx == 0) m_ctrl = (m_ctrl & ~bm) | (wd & bm);
         if (idx == 1) m_pend = m_pend & ~(wd & bm);
         if (idx == 2) m_mask = ((m_mask & ~bm) | (wd & bm)) & 32'hF;
         if (idx >= 4 && idx < 8) m_scr[idx-4] = (m_scr[idx-4] & ~bm) | (wd & bm);
      end
      if (idx < NIDX) begin
         if (!r && idx == 8) begin m_rd = 0; m_wr = 0; end
         else if (r) m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
         else        m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
      end
   endtask

   // One bus transaction; also checks latency, idle read_data and the ack pulse width.
   task automatic xact(input int u, input bit r, input int idx, input logic [3:0] be,
                       input logic [31:0] wd, input bit pulse, output logic [31:0] rd);
      int lat;
      bit got;
      @(posedge clk); #1;
      bus_en[u] = 1'b1; rw_s[u] = r; addr_s[u] = 17'(idx * 4); be_s[u] = be; wd_s[u] = wd;
      lat = 0; got = 0; rd = '0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (ack_s[u]) begin
            got = 1; rd = rdata_s[u]; bus_en[u] = 1'b0;
            if (pulse) src0 = 4'b0010;
         end else begin
            chk("rd_idle", rdata_s[u], 32'h0);
            addr_s[u] = 17'($urandom); wd_s[u] = $urandom;
         end
      end
      bus_en[u] = 1'b0;
      chk("ack_lat", 32'(lat), (u == 0) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      chk("ack_pulse", 32'(ack_s[u]), 32'h0);
      chk("rd_after", rdata_s[u], 32'h0);
      src0 = 4'b0;
   endtask

   task automatic run(input bit r, input int idx, input logic [3:0] be, input logic [31:0] wd,
                      input bit pulse, output logic [31:0] rd);
      logic [31:0] exp, st;
      st = $urandom; st_s[0] = st;
      exp = m_read(idx, st);
      xact(0, r, idx, be, wd, pulse, rd);
      if (r) chk("rdata", rd, exp);
      m_apply(r, idx, be, wd);
      if (pulse) m_pend = m_pend | 32'h2;
      @(posedge clk); #1;
      chk("irq", 32'(irq_s[0]), 32'(|(m_pend & m_mask)));
      chk("ctrl_out", 32'(ctrl_s[0]), m_ctrl & 32'hFF);
   endtask

   task automatic pulse_src(input logic [3:0] b);
      @(posedge clk); #1; src0 = b;
      @(posedge clk); #1; src0 = 4'b0;
      m_pend = m_pend | 32'(b);
      @(posedge clk); #1;
      chk("irq_pulse", 32'(irq_s[0]), 32'(|(m_pend & m_mask)));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] d [3];
      int k;
      rst = 1'b1; src0 = '0; src1 = '0;
      for (int u = 0; u < 2; u++) begin
         bus_en[u] = 0; rw_s[u] = 0; addr_s[u] = '0; be_s[u] = '0; wd_s[u] = '0; st_s[u] = '0;
      end
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack",  32'(ack_s[0]), 32'h0);
      chk("rst_irq",  32'(irq_s[0]), 32'h0);
      chk("rst_rd",   rdata_s[0], 32'h0);
      chk("rst_ctrl", 32'(ctrl_s[0]), 32'h0);
      rst = 1'b0;

      run(1, 0, 4'hF, 0, 0, rd);
      chk("ctrl_rst_val", rd, 32'h0);

      run(0, 4, 4'b0101, 32'hA5A5A5A5, 0, rd);
      run(1, 4, 4'hF, 0, 0, rd);
      chk("scratch_be", rd, 32'h00A500A5);

      run(0, 2, 4'hF, 32'h3, 0, rd);
      pulse_src(4'b0010);
      run(1, 1, 4'hF, 0, 0, rd);
      chk("pend_set", rd, 32'h2);
      run(0, 1, 4'hF, 32'h2, 0, rd);
      chk("irq_cleared", 32'(irq_s[0]), 32'h0);
      run(0, 1, 4'hF, 32'h2, 1, rd);
      run(1, 1, 4'hF, 0, 0, rd);
      chk("pend_set_wins", rd, 32'h2);

      run(1, 32'h7FFF, 4'hF, 0, 0, rd);
      chk("oor_read", rd, 32'h0);
      run(0, 32'h7FFF, 4'hF, 32'hFFFFFFFF, 0, rd);
      for (int i = 0; i < 8; i++) run(1, i, 4'hF, 0, 0, rd);

      for (int n = 0; n < 80; n++) begin
         int idx;
         idx = int'($urandom_range(0, 10));
         if (idx == 10) idx = 32'h7FFF;
         run(1'($urandom_range(0, 1)), idx, 4'($urandom), $urandom, 0, rd);
         if ($urandom_range(0, 3) == 0) pulse_src(4'($urandom));
      end

      // Back-to-back writes on the zero-wait-state instance.
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      @(posedge clk); #1;
      bus_en[1] = 1'b1; rw_s[1] = 1'b0; be_s[1] = 4'hF; addr_s[1] = 17'(16); wd_s[1] = d[0];
      k = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("b2b_ack", 32'(ack_s[1]), (c % 2 == 0) ? 32'h1 : 32'h0);
         if (ack_s[1] && k < 3) begin
            k++;
            if (k < 3) begin addr_s[1] = 17'((4 + k) * 4); wd_s[1] = d[k]; end
            else bus_en[1] = 1'b0;
         end
      end
      bus_en[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         xact(1, 1, 4 + i, 4'hF, 0, 0, rd);
         chk("b2b_data", rd, d[i]);
      end

      // Reset asserted in the WAIT cycle of a CTRL write.
      run(0, 0, 4'hF, 32'h0000_00C3, 0, rd);
      @(posedge clk); #1;
      bus_en[0] = 1'b1; rw_s[0] = 1'b0; addr_s[0] = '0; be_s[0] = 4'hF; wd_s[0] = 32'h5A;
      @(posedge clk); #1;
      chk("wait_noack", 32'(ack_s[0]), 32'h0);
      rst = 1'b1; bus_en[0] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_noack", 32'(ack_s[0]), 32'h0);
      end
      chk("rst_ctrl_out", 32'(ctrl_s[0]), 32'h0);
      rst = 1'b0;
      m_reset();
      run(1, 0, 4'hF, 0, 0, rd);
      chk("ctrl_after_rst", rd, 32'h0);

`ifdef EXT_BUS_STATS_EN
      run(0, 8, 4'h0, 32'hFFFF_FFFF, 0, rd);
      for (int i = 0; i < 3; i++) run(1, i, 4'hF, 0, 0, rd);
      run(0, 5, 4'hF, 32'h1234, 0, rd);
      run(0, 6, 4'hF, 32'h5678, 0, rd);
      run(1, 8, 4'hF, 0, 0, rd);
      chk("stats", rd, 32'h00020004);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
